// File: rtl/dct_pkg.sv
// Shared constants, types and FSM encoding for the 8-point forward and inverse DCT.
// Both directions use the same integer cosine factors and width constants.
package dct_pkg;
  localparam int DATA_IN_SIGNED_WIDTH  = 19;
  localparam int DATA_OUT_SIGNED_WIDTH = 9;
  localparam int FACTOR_SIGNED_WIDTH   = 5;
  localparam int ACC_WIDTH             = 28;
  localparam int SHIFT                 = 10;
  localparam int NUM_PTS               = 8;

  typedef logic signed [FACTOR_SIGNED_WIDTH-1:0]   fac_t;
  typedef logic signed [DATA_IN_SIGNED_WIDTH-1:0]  coef_t;
  typedef logic signed [ACC_WIDTH-1:0]             acc_t;
  typedef logic signed [DATA_OUT_SIGNED_WIDTH-1:0] smp_t;

  localparam fac_t C1 = 5'sd15;
  localparam fac_t C2 = 5'sd14;
  localparam fac_t C3 = 5'sd13;
  localparam fac_t C4 = 5'sd11;
  localparam fac_t C5 = 5'sd9;
  localparam fac_t C6 = 5'sd6;
  localparam fac_t C7 = 5'sd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    SUM  = 3'd2,
    BFLY = 3'd3,
    OUT  = 3'd4
  } idct_state_e;

  function automatic acc_t fmul(coef_t x, fac_t c);
    return acc_t'(x) * acc_t'(c);
  endfunction
endpackage

// File: rtl/idct_8point_if.sv
// Coefficient-in / sample-out handshake bundle for the 8-point IDCT.
interface idct_8point_if;
  import dct_pkg::*;
  logic                      ena;
  coef_t [NUM_PTS-1:0]       data_in;
  smp_t  [NUM_PTS-1:0]       data_out;
  logic                      done;
  logic                      busy;

  modport master (output ena, data_in, input data_out, done, busy);
  modport slave  (input ena, data_in, output data_out, done, busy);
endinterface

// File: rtl/idct_round_sat.sv
// Round-half-up, arithmetic shift by SHIFT, then clamp into the signed sample range.
module idct_round_sat
  import dct_pkg::*;
(
  input  acc_t acc,
  output smp_t q
);
  localparam acc_t RND  = acc_t'(1 << (SHIFT - 1));
  localparam acc_t MAXV = acc_t'((1 << (DATA_OUT_SIGNED_WIDTH - 1)) - 1);
  localparam acc_t MINV = -acc_t'(1 << (DATA_OUT_SIGNED_WIDTH - 1));

  acc_t sh;

  always_comb begin
    sh = (acc + RND) >>> SHIFT;
    if (sh > MAXV)      q = smp_t'(MAXV);
    else if (sh < MINV) q = smp_t'(MINV);
    else                q = smp_t'(sh);
  end
endmodule

// File: rtl/idct_8point.sv
// 8-point inverse DCT: capture, multiply, even/odd sums, butterfly, round/saturate.
// One vector every five cycles; results registered on the OUT edge.
module idct_8point
  import dct_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  idct_8point_if.slave  io
);
  localparam fac_t ODD_F [4] = '{C1, C3, C5, C7};

  idct_state_e state, state_nxt;

  coef_t x_r [NUM_PTS];
  acc_t  po  [4][4];  // po[j][k] = X(2j+1) * ODD_F[k]
  acc_t  pe  [6];
  acc_t  ev  [4];
  acc_t  od  [4];
  acc_t  [NUM_PTS-1:0] acc_r;
  smp_t  [NUM_PTS-1:0] sat_q;
  smp_t  [NUM_PTS-1:0] dout;
  logic  done_r, busy_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = io.ena ? MUL : IDLE;
      MUL:     state_nxt = SUM;
      SUM:     state_nxt = BFLY;
      BFLY:    state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PTS; i++) x_r[i] <= '0;
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) po[j][k] <= '0;
      for (int i = 0; i < 6; i++) pe[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        ev[i] <= '0;
        od[i] <= '0;
      end
      acc_r  <= '0;
      dout   <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (io.ena) begin
          for (int i = 0; i < NUM_PTS; i++) x_r[i] <= io.data_in[i];
          busy_r <= 1'b1;
        end
        MUL: begin
          for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) po[j][k] <= fmul(x_r[2*j+1], ODD_F[k]);
          pe[0] <= fmul(x_r[0], C4);
          pe[1] <= fmul(x_r[2], C2);
          pe[2] <= fmul(x_r[2], C6);
          pe[3] <= fmul(x_r[4], C4);
          pe[4] <= fmul(x_r[6], C6);
          pe[5] <= fmul(x_r[6], C2);
        end
        SUM: begin
          ev[0] <= pe[0] + pe[1] + pe[3] + pe[4];
          ev[1] <= pe[0] + pe[2] - pe[3] - pe[5];
          ev[2] <= pe[0] - pe[2] - pe[3] + pe[5];
          ev[3] <= pe[0] - pe[1] + pe[3] - pe[4];
          od[0] <= po[0][0] + po[1][1] + po[2][2] + po[3][3];
          od[1] <= po[0][1] - po[1][3] - po[2][0] - po[3][2];
          od[2] <= po[0][2] - po[1][0] + po[2][3] + po[3][1];
          od[3] <= po[0][3] - po[1][2] + po[2][1] - po[3][0];
        end
        BFLY: begin
          for (int n = 0; n < 4; n++) begin
            acc_r[n]   <= ev[n] + od[n];
            acc_r[7-n] <= ev[n] - od[n];
          end
        end
        OUT: begin
          dout   <= sat_q;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  idct_round_sat u_rs [NUM_PTS-1:0] (.acc(acc_r), .q(sat_q));

  assign io.data_out = dout;
  assign io.done     = done_r;
  assign io.busy     = busy_r;
endmodule

// File: tb/tb_idct_8point.sv
// Scoreboarded bench for idct_8point: expected vectors come from a direct matrix model.
module tb_idct_8point;
  import dct_pkg::*;

  typedef coef_t [7:0] cvec_t;
  typedef smp_t  [7:0] svec_t;

  // Forward integer cosine matrix, row k = basis k; IDCT uses column n.
  localparam int MTX [8][8] = '{
    '{11,  11,  11,  11,  11,  11,  11,  11},
    '{15,  13,   9,   3,  -3,  -9, -13, -15},
    '{14,   6,  -6, -14, -14,  -6,   6,  14},
    '{13,  -3, -15,  -9,   9,  15,   3, -13},
    '{11, -11, -11,  11,  11, -11, -11,  11},
    '{ 9, -15,   3,  13, -13,  -3,  15,  -9},
    '{ 6, -14,  14,  -6,  -6,  14, -14,   6},
    '{ 3,  -9,  13, -15,  15, -13,   9,  -3}
  };

  localparam int KNOWN [4][8] = '{
    '{  95,   95,   95,   95,   95,   95,   95,   95},
    '{  15,   13,    9,    3,   -3,   -9,  -13,  -15},
    '{ 255,  255,  255,  255,  255,  255,  255,  255},
    '{-256, -256, -256, -256, -256, -256, -256, -256}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  idct_8point_if io();

  idct_8point dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  svec_t exp_q [$];

  function automatic svec_t model(cvec_t x);
    svec_t r;
    int s;
    for (int n = 0; n < 8; n++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += MTX[k][n] * int'($signed(x[k]));
      s = (s + 512) >>> 10;
      if (s > 255)  s = 255;
      if (s < -256) s = -256;
      r[n] = smp_t'(s);
    end
    return r;
  endfunction

  task automatic drive(input cvec_t v);
    io.data_in = v;
    io.ena     = 1'b1;
    exp_q.push_back(model(v));
  endtask

  function automatic cvec_t rand_vec(input bit full);
    cvec_t v;
    for (int i = 0; i < 8; i++)
      v[i] = full ? coef_t'($urandom) : coef_t'(int'($urandom_range(0, 8000)) - 4000);
    return v;
  endfunction

  task automatic test_reset();
    io.ena = 1'b0;
    io.data_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_tot++;
    if (io.busy !== 1'b0 || io.done !== 1'b0)
      $display("FAIL reset_flags busy=%b done=%b want 0/0", io.busy, io.done);
    else n_pass++;
    n_tot++;
    if (io.data_out !== '0) $display("FAIL reset_out got %h want 0", io.data_out);
    else n_pass++;
  endtask

  task automatic test_zero_latency();
    svec_t e;
    @(negedge clk);
    drive('0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      io.ena = 1'b0;
      n_tot++;
      if (io.busy !== 1'b1 || io.done !== 1'b0)
        $display("FAIL zero_busy cyc=%0d busy=%b done=%b want 1/0", c, io.busy, io.done);
      else n_pass++;
    end
    @(negedge clk);
    n_tot++;
    if (io.done !== 1'b1 || io.busy !== 1'b0)
      $display("FAIL zero_done done=%b busy=%b want 1/0", io.done, io.busy);
    else n_pass++;
    e = exp_q.pop_front();
    n_tot++;
    if (io.data_out !== e) $display("FAIL zero_out got %h want %h", io.data_out, e);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (io.done !== 1'b0) $display("FAIL zero_pulse done=%b want 0", io.done);
    else n_pass++;
  endtask

  task automatic test_vectors();
    cvec_t v;
    svec_t e;
    int cnt;
    for (int t = 0; t < 7; t++) begin
      v = '0;
      case (t)
        0: v[0] = coef_t'(8800);
        1: v[1] = coef_t'(1024);
        2: v[0] = coef_t'(262143);
        3: v[0] = coef_t'(-262144);
        default: v = rand_vec(t == 6);
      endcase
      @(negedge clk);
      drive(v);
      @(negedge clk);
      io.ena = 1'b0;
      io.data_in = rand_vec(1'b1);
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (io.done !== 1'b1 && cnt < 12);
      n_tot++;
      if (cnt != 4) $display("FAIL vec%0d_latency got %0d want 4", t, cnt);
      else n_pass++;
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL vec%0d_sb got empty scoreboard want entry", t);
      end else begin
        e = exp_q.pop_front();
        n_tot++;
        if (io.data_out !== e) $display("FAIL vec%0d_model got %h want %h", t, io.data_out, e);
        else n_pass++;
      end
      if (t < 4)
        for (int n = 0; n < 8; n++) begin
          n_tot++;
          if (io.data_out[n] !== smp_t'(KNOWN[t][n]))
            $display("FAIL vec%0d_x%0d got %0d want %0d", t, n, $signed(io.data_out[n]), KNOWN[t][n]);
          else n_pass++;
        end
    end
  endtask

  task automatic test_ignore_ena();
    svec_t e;
    int ndone = 0;
    @(negedge clk);
    drive(rand_vec(1'b0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      io.data_in = rand_vec(1'b0);
    end
    @(negedge clk);
    io.ena = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (io.done === 1'b1) begin
        ndone++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_tot++;
        if (io.data_out !== e) $display("FAIL ignore_out got %h want %h", io.data_out, e);
        else n_pass++;
      end
    end
    n_tot++;
    if (ndone != 1) $display("FAIL ignore_count got %0d dones want 1", ndone);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    svec_t e;
    int cnt;
    @(negedge clk);
    drive(rand_vec(1'b0));
    for (int v = 0; v < 6; v++) begin
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (io.done !== 1'b1 && cnt < 12);
      n_tot++;
      if (cnt != 5) $display("FAIL b2b%0d_spacing got %0d want 5", v, cnt);
      else n_pass++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_tot++;
      if (io.data_out !== e) $display("FAIL b2b%0d_out got %h want %h", v, io.data_out, e);
      else n_pass++;
      if (v < 5) drive(rand_vec(v[0]));
      else io.ena = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    @(negedge clk);
    drive(rand_vec(1'b0));
    @(negedge clk);
    io.ena = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    n_tot++;
    if (io.busy !== 1'b0 || io.done !== 1'b0)
      $display("FAIL abort_flags busy=%b done=%b want 0/0", io.busy, io.done);
    else n_pass++;
    n_tot++;
    if (io.data_out !== '0) $display("FAIL abort_out got %h want 0", io.data_out);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (io.done === 1'b1) ndone++;
    end
    n_tot++;
    if (ndone != 0) $display("FAIL abort_nodone got %0d dones want 0", ndone);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_vectors();
    test_ignore_ena();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
